// File: rtl/comparator_bist.sv
// comparator_bist: self-test driver for a magnitude comparator.
// It walks a ramp, a set of corner vectors and LFSR random pairs across the
// A/B operands. Each vector gets SETTLE cycles before the Same/A_High/B_High
// flags are compared against a golden model. The block reports a pass flag,
// a saturating error count and the index of the first failing vector.
module comparator_bist #(
  parameter int          WIDTH      = 20,
  parameter int          NUM_RANDOM = 16,
  parameter int          SETTLE     = 1,
  parameter logic [19:0] SEED       = 20'h1ACE5
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             start,
  output logic [WIDTH-1:0] A,
  output logic [WIDTH-1:0] B,
  input  logic             Same,
  input  logic             A_High,
  input  logic             B_High,
  output logic             busy,
  output logic             done,
  output logic             pass,
  output logic [7:0]       err_count,
  output logic [7:0]       first_fail_idx,
  output logic [7:0]       vec_idx
);

  localparam int          TOTAL    = 15 + NUM_RANDOM;
  localparam logic [7:0]  LAST_IDX = 8'(TOTAL - 1);
  localparam int          CW       = $clog2(SETTLE + 1);
  localparam logic [19:0] SEED_EFF = (SEED == 20'd0) ? 20'd1 : SEED;

  localparam logic [2:0] S_IDLE  = 3'd0;
  localparam logic [2:0] S_DRIVE = 3'd1;
  localparam logic [2:0] S_WAIT  = 3'd2;
  localparam logic [2:0] S_CHECK = 3'd3;
  localparam logic [2:0] S_DONE  = 3'd4;

  // Fibonacci LFSR x^20+x^17+1: shift left, bit19^bit16 enters bit 0.
  // A non-zero state never maps to zero.
  function automatic logic [19:0] lfsr_next(input logic [19:0] x);
    return {x[18:0], x[19] ^ x[16]};
  endfunction

  logic [2:0]    state;
  logic [CW-1:0] settle_cnt;
  logic [19:0]   lfsr;
  logic [19:0]   lfsr_1;
  logic [19:0]   lfsr_2;
  logic [19:0]   vec_a;
  logic [19:0]   vec_b;
  logic          mismatch;
  logic [7:0]    err_inc;

  assign lfsr_1 = lfsr_next(lfsr);
  assign lfsr_2 = lfsr_next(lfsr_1);

  // Vector table: ramp, corner cases, then the current LFSR pair.
  always_comb begin
    // NOTE: every combinational output gets a default first so no path
    // through the case leaves it unassigned and infers a latch.
    vec_a = lfsr;
    vec_b = lfsr_1;
    case (vec_idx)
      8'd0:  begin vec_a = 20'd1;       vec_b = 20'd0;       end
      8'd1:  begin vec_a = 20'd2;       vec_b = 20'd0;       end
      8'd2:  begin vec_a = 20'd2;       vec_b = 20'd1;       end
      8'd3:  begin vec_a = 20'd3;       vec_b = 20'd0;       end
      8'd4:  begin vec_a = 20'd3;       vec_b = 20'd1;       end
      8'd5:  begin vec_a = 20'd3;       vec_b = 20'd2;       end
      8'd6:  begin vec_a = 20'd4;       vec_b = 20'd0;       end
      8'd7:  begin vec_a = 20'd4;       vec_b = 20'd1;       end
      8'd8:  begin vec_a = 20'd4;       vec_b = 20'd2;       end
      8'd9:  begin vec_a = 20'd4;       vec_b = 20'd3;       end
      8'd10: begin vec_a = 20'hFFFFF;   vec_b = 20'h00000;   end
      8'd11: begin vec_a = 20'h807FF;   vec_b = 20'hFFFD8;   end
      8'd12: begin vec_a = 20'hFFFFF;   vec_b = 20'hFFFFF;   end
      8'd13: begin vec_a = 20'h00000;   vec_b = 20'h00000;   end
      8'd14: begin vec_a = 20'hFCFFF;   vec_b = 20'h0F800;   end
      default: ;
    endcase
  end

  // Golden comparison of the applied operands against the DUT flags.
  always_comb begin
    mismatch = (Same   != (A == B)) ||
               (A_High != (A >  B)) ||
               (B_High != (A <  B));
    err_inc  = (err_count == 8'hFF) ? 8'hFF : err_count + 8'd1;
  end

  // Sequencer: drive, settle, check, advance; results held in DONE.
  always_ff @(posedge clk or posedge rst) begin
    // NOTE: all state uses non-blocking assignments so every register
    // samples pre-edge values regardless of statement order.
    if (rst) begin
      state          <= S_IDLE;
      settle_cnt     <= '0;
      lfsr           <= SEED_EFF;
      A              <= '0;
      B              <= '0;
      busy           <= 1'b0;
      done           <= 1'b0;
      pass           <= 1'b0;
      err_count      <= 8'd0;
      first_fail_idx <= 8'hFF;
      vec_idx        <= 8'd0;
    end else begin
      case (state)
        S_IDLE, S_DONE: begin
          if (start) begin
            state          <= S_DRIVE;
            lfsr           <= SEED_EFF;
            busy           <= 1'b1;
            done           <= 1'b0;
            pass           <= 1'b0;
            err_count      <= 8'd0;
            first_fail_idx <= 8'hFF;
            vec_idx        <= 8'd0;
          end
        end
        S_DRIVE: begin
          A          <= WIDTH'(vec_a);
          B          <= WIDTH'(vec_b);
          if (vec_idx >= 8'd15) lfsr <= lfsr_2;
          settle_cnt <= CW'(SETTLE);
          state      <= S_WAIT;
        end
        S_WAIT: begin
          if (settle_cnt == CW'(1)) state <= S_CHECK;
          else settle_cnt <= settle_cnt - CW'(1);
        end
        S_CHECK: begin
          if (mismatch) begin
            err_count <= err_inc;
            if (first_fail_idx == 8'hFF) first_fail_idx <= vec_idx;
          end
          if (vec_idx == LAST_IDX) begin
            state <= S_DONE;
            busy  <= 1'b0;
            done  <= 1'b1;
            pass  <= (err_count == 8'd0) && !mismatch;
          end else begin
            vec_idx <= vec_idx + 8'd1;
            state   <= S_DRIVE;
          end
        end
        default: state <= S_IDLE;
      endcase
    end
  end

endmodule

// File: tb/tb_comparator_bist.sv
// tb_comparator_bist: directed checks of comparator_bist with behavioural
// comparators (optionally faulty) attached to three differently
// parameterised instances.
module tb_comparator_bist;

  logic clk = 1'b0;
  logic rst;
  always #5 clk = ~clk;

  // Instance 0: defaults; 1: NUM_RANDOM=0; 2: SEED=0, NUM_RANDOM=2.
  logic        start_i [3];
  logic [19:0] a_o     [3];
  logic [19:0] b_o     [3];
  logic        same_i  [3];
  logic        ahi_i   [3];
  logic        bhi_i   [3];
  logic        busy_o  [3];
  logic        done_o  [3];
  logic        pass_o  [3];
  logic [7:0]  err_o   [3];
  logic [7:0]  ffi_o   [3];
  logic [7:0]  idx_o   [3];
  int          mode    [3];   // 0 good, 1 Same stuck at 0, 2 A_High/B_High swapped

  for (genvar g = 0; g < 3; g++) begin : g_cmp
    assign same_i[g] = (mode[g] == 1) ? 1'b0 : (a_o[g] == b_o[g]);
    assign ahi_i[g]  = (mode[g] == 2) ? (a_o[g] < b_o[g]) : (a_o[g] > b_o[g]);
    assign bhi_i[g]  = (mode[g] == 2) ? (a_o[g] > b_o[g]) : (a_o[g] < b_o[g]);
  end

  comparator_bist u_main (
    .clk(clk), .rst(rst), .start(start_i[0]), .A(a_o[0]), .B(b_o[0]),
    .Same(same_i[0]), .A_High(ahi_i[0]), .B_High(bhi_i[0]),
    .busy(busy_o[0]), .done(done_o[0]), .pass(pass_o[0]),
    .err_count(err_o[0]), .first_fail_idx(ffi_o[0]), .vec_idx(idx_o[0])
  );

  comparator_bist #(.NUM_RANDOM(0)) u_zero (
    .clk(clk), .rst(rst), .start(start_i[1]), .A(a_o[1]), .B(b_o[1]),
    .Same(same_i[1]), .A_High(ahi_i[1]), .B_High(bhi_i[1]),
    .busy(busy_o[1]), .done(done_o[1]), .pass(pass_o[1]),
    .err_count(err_o[1]), .first_fail_idx(ffi_o[1]), .vec_idx(idx_o[1])
  );

  comparator_bist #(.NUM_RANDOM(2), .SEED(20'h00000)) u_seed (
    .clk(clk), .rst(rst), .start(start_i[2]), .A(a_o[2]), .B(b_o[2]),
    .Same(same_i[2]), .A_High(ahi_i[2]), .B_High(bhi_i[2]),
    .busy(busy_o[2]), .done(done_o[2]), .pass(pass_o[2]),
    .err_count(err_o[2]), .first_fail_idx(ffi_o[2]), .vec_idx(idx_o[2])
  );

  int tests  = 0;
  int failed = 0;

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    tests++;
    if (got !== exp) begin
      failed++;
      $display("FAIL %s: got %0h expected %0h", tag, got, exp);
    end
  endtask

  function automatic logic [19:0] lfsr_step(input logic [19:0] x);
    return {x[18:0], x[19] ^ x[16]};
  endfunction

  task automatic pulse_start(input int w);
    @(negedge clk);
    start_i[w] = 1'b1;
    @(negedge clk);
    start_i[w] = 1'b0;
  endtask

  // Returns at the first negedge where vec_idx equals idx; n = negedges waited.
  task automatic wait_idx(input int w, input logic [7:0] idx, output int n);
    n = 0;
    while (idx_o[w] != idx && n < 500) begin
      @(negedge clk);
      n++;
    end
    check("wait_idx_timeout", 32'(n < 500), 32'd1);
  endtask

  task automatic wait_done(input int w, output int n);
    n = 0;
    while (!done_o[w] && n < 500) begin
      @(negedge clk);
      n++;
    end
    check("wait_done_timeout", 32'(n < 500), 32'd1);
  endtask

  task automatic check_reset_state(input string tag);
    check({tag, "_busy"}, 32'(busy_o[0]), 32'd0);
    check({tag, "_done"}, 32'(done_o[0]), 32'd0);
    check({tag, "_pass"}, 32'(pass_o[0]), 32'd0);
    check({tag, "_err"},  32'(err_o[0]),  32'd0);
    check({tag, "_ffi"},  32'(ffi_o[0]),  32'hFF);
    check({tag, "_idx"},  32'(idx_o[0]),  32'd0);
    check({tag, "_A"},    32'(a_o[0]),    32'd0);
    check({tag, "_B"},    32'(b_o[0]),    32'd0);
  endtask

  initial begin
    int k, m;
    logic [19:0] l, exp_a, exp_b;

    rst = 1'b1;
    for (int i = 0; i < 3; i++) begin
      start_i[i] = 1'b0;
      mode[i]    = 0;
    end
    repeat (2) @(negedge clk);
    rst = 1'b0;
    @(negedge clk);
    check_reset_state("reset");

    // Full run with a good comparator, corner vector 11 spot-checked.
    pulse_start(0);
    check("run1_busy", 32'(busy_o[0]), 32'd1);
    wait_idx(0, 8'd11, k);
    @(negedge clk);
    check("run1_vec11_A", 32'(a_o[0]), 32'h807FF);
    check("run1_vec11_B", 32'(b_o[0]), 32'hFFFD8);
    wait_done(0, m);
    check("run1_cycles", 32'(k + 1 + m), 32'd93);
    check("run1_pass", 32'(pass_o[0]), 32'd1);
    check("run1_err",  32'(err_o[0]),  32'd0);
    check("run1_ffi",  32'(ffi_o[0]),  32'hFF);
    check("run1_busy_end", 32'(busy_o[0]), 32'd0);
    l = 20'h1ACE5;
    exp_a = 20'd0;
    exp_b = 20'd0;
    for (int i = 0; i < 16; i++) begin
      exp_a = l;
      exp_b = lfsr_step(l);
      l = lfsr_step(exp_b);
    end
    check("run1_last_A", 32'(a_o[0]), 32'(exp_a));
    check("run1_last_B", 32'(b_o[0]), 32'(exp_b));

    // Restart from DONE; a start pulse at idx 3 must be ignored.
    pulse_start(0);
    check("run2_done_clr", 32'(done_o[0]), 32'd0);
    check("run2_idx0", 32'(idx_o[0]), 32'd0);
    wait_idx(0, 8'd3, k);
    pulse_start(0);
    check("run2_busy_mid", 32'(busy_o[0]), 32'd1);
    wait_done(0, m);
    check("run2_cycles", 32'(k + 2 + m), 32'd93);
    check("run2_pass", 32'(pass_o[0]), 32'd1);
    check("run2_err",  32'(err_o[0]),  32'd0);

    // Reset in the WAIT of vector 7, with start raised alongside it.
    pulse_start(0);
    wait_idx(0, 8'd7, k);
    @(negedge clk);
    rst = 1'b1;
    start_i[0] = 1'b1;
    #1;
    check_reset_state("midrst");
    @(negedge clk);
    check("rst_wins_busy", 32'(busy_o[0]), 32'd0);
    rst = 1'b0;
    start_i[0] = 1'b0;
    pulse_start(0);
    wait_done(0, m);
    check("run3_cycles", 32'(m), 32'd93);
    check("run3_pass", 32'(pass_o[0]), 32'd1);
    check("run3_err",  32'(err_o[0]),  32'd0);

    // Same stuck at 0: only idx 12 and 13 have A==B.
    mode[1] = 1;
    pulse_start(1);
    wait_done(1, m);
    check("stuck_cycles", 32'(m), 32'd45);
    check("stuck_err",  32'(err_o[1]), 32'd2);
    check("stuck_ffi",  32'(ffi_o[1]), 32'd12);
    check("stuck_pass", 32'(pass_o[1]), 32'd0);

    // A_High/B_High swapped: every unequal vector fails (13 of 15).
    mode[1] = 2;
    pulse_start(1);
    check("swap_err_clr", 32'(err_o[1]), 32'd0);
    check("swap_ffi_clr", 32'(ffi_o[1]), 32'hFF);
    wait_done(1, m);
    check("swap_err",  32'(err_o[1]), 32'd13);
    check("swap_ffi",  32'(ffi_o[1]), 32'd0);
    check("swap_pass", 32'(pass_o[1]), 32'd0);

    // SEED=0 is replaced by 1; random pairs follow the LFSR sequence.
    pulse_start(2);
    wait_idx(2, 8'd15, k);
    @(negedge clk);
    check("seed_v15_A", 32'(a_o[2]), 32'h00001);
    check("seed_v15_B", 32'(b_o[2]), 32'h00002);
    wait_idx(2, 8'd16, k);
    @(negedge clk);
    check("seed_v16_A", 32'(a_o[2]), 32'h00004);
    check("seed_v16_B", 32'(b_o[2]), 32'h00008);
    wait_done(2, m);
    check("seed_pass", 32'(pass_o[2]), 32'd1);
    check("seed_err",  32'(err_o[2]),  32'd0);

    $display("[TB] %0d tests run, %0d failed", tests, failed);
    $finish;
  end

endmodule

// File: doc/comparator_bist.md
Name: comparator_bist

Overview:
Sequential stimulus generator and response checker that drives the A/B operand inputs of the 20-bit magnitude comparator and checks its Same/A_High/B_High outputs. It applies three phases of vectors: a small exhaustive ramp, fixed corner vectors, and LFSR random pairs. It compares each DUT response against an internal golden model and reports pass/fail, an error count and the index of the first failing vector. It sits beside the comparator as its on-chip self-test driver.

Parameters:
WIDTH, 20, operand width (corner vectors defined for 20; wider widths zero-extend them)
NUM_RANDOM, 16, number of LFSR random vector pairs (0 allowed)
SETTLE, 1, cycles to wait after driving A/B before sampling DUT flags (>=1)
SEED, 20'h1ACE5, LFSR seed; value 0 replaced by 1

Ports:
clk  input  1  clock, rising edge
rst  input  1  asynchronous, active-high reset
start  input  1  one-cycle pulse, begins a run when idle
A  output  WIDTH  operand A to comparator, registered
B  output  WIDTH  operand B to comparator, registered
Same  input  1  DUT flag A==B
A_High  input  1  DUT flag A>B
B_High  input  1  DUT flag A<B
busy  output  1  high from the cycle after start until done
done  output  1  high in DONE; held until next start or reset
pass  output  1  valid when done=1: err_count==0
err_count  output  8  mismatching vectors, saturates at 255
first_fail_idx  output  8  index of first mismatching vector; 8'hFF if none
vec_idx  output  8  index of vector currently applied

Behaviour:
- Reset (async, immediate): state=IDLE; A=B=0; busy=done=pass=0; err_count=0; first_fail_idx=8'hFF; vec_idx=0; lfsr=SEED (or 1 if SEED==0). Reset mid-run aborts with no partial result retained.
- FSM states: IDLE, DRIVE, WAIT, CHECK, DONE.
- IDLE/DONE + start=1 -> DRIVE. On this transition: err_count=0, first_fail_idx=8'hFF, vec_idx=0, done=0, pass=0, lfsr reloaded. start is ignored in DRIVE/WAIT/CHECK.
- DRIVE (1 cycle): A/B registers load vector vec_idx -> WAIT with settle counter=SETTLE.
- WAIT: decrement counter; at 1 -> CHECK. Total settle is SETTLE cycles.
- CHECK (1 cycle): golden model is same=(A==B), ahi=(A>B) unsigned, bhi=(A<B). A mismatch is any of the three DUT flags differing from golden. On mismatch: err_count+=1 (saturating); if first_fail_idx==8'hFF, load vec_idx. If vec_idx==TOTAL-1 -> DONE, else vec_idx+=1 -> DRIVE.
- TOTAL = 15 + NUM_RANDOM. Cycles per vector = 2+SETTLE. done asserts (2+SETTLE)*TOTAL cycles after the start cycle.
- Vector order:
  - idx 0-9: (1,0),(2,0),(2,1),(3,0),(3,1),(3,2),(4,0),(4,1),(4,2),(4,3).
  - idx 10-14: (FFFFF,00000),(807FF,FFFD8),(FFFFF,FFFFF),(00000,00000),(FCFFF,0F800).
  - idx 15+: random. In DRIVE: A<=lfsr, B<=nxt(lfsr), lfsr<=nxt(nxt(lfsr)).
- LFSR: 20-bit Fibonacci, polynomial x^20+x^17+1, shift left, feedback=bit19^bit16 into bit0. It never reaches 0.
- DONE: busy=0, done=1, pass=(err_count==0). A/B hold the last vector.
- busy=1 in DRIVE/WAIT/CHECK only.
- Simultaneous start and rst: rst wins.

Test Plan:
- Correct behavioural comparator, NUM_RANDOM=16, SETTLE=1: pulse start -> done at cycle 93, pass=1, err_count=0, first_fail_idx=8'hFF.
- Comparator with Same stuck at 0, NUM_RANDOM=0: -> err_count=2, first_fail_idx=12, pass=0.
- Comparator with A_High/B_High swapped, NUM_RANDOM=0: -> err_count=13, first_fail_idx=0.
- Assert rst during vector idx 7 WAIT: -> all outputs at reset values within the same cycle. A new start yields a full correct run (err_count=0).
- Pulse start again at idx 3 while busy: -> ignored; run completes unchanged. Start in DONE clears err_count/done and restarts from idx 0.
- SEED=0, NUM_RANDOM=2: -> idx 15 drives A=20'h00001, B=20'h00002; idx 16 drives A=20'h00004, B=20'h00008. Correct DUT gives pass=1.
